timer_seq: RTL
==============

TIMER_SEQ -- requirements
Module: timer_seq

Interface
REQ-001 SHALL provide parameter SEL_VAL, default 1'b0, timer clock select driven on sel (0 = 1 MHz, 1 = 0.5 MHz).
REQ-002 SHALL provide parameter CLR_CODE, default 8'h80, startstop value that clears the counters.
REQ-003 SHALL provide parameter RUN_CODE, default 8'h01, startstop value that starts the counters.
REQ-004 SHALL have port clk  input  1  single system clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start_req  input  1  one-cycle pulse requesting the configure-and-start sequence.
REQ-007 SHALL have port stop_req  input  1  one-cycle pulse requesting the stop sequence.
REQ-008 SHALL have port cfg_t1  input  8  timer1 register value.
REQ-009 SHALL have port cfg_t2  input  8  timer2 register value.
REQ-010 SHALL have port sel  output  1  timer clock select.
REQ-011 SHALL have port write  output  1  timer register write strobe.
REQ-012 SHALL have port read  output  1  timer register read strobe.
REQ-013 SHALL have port addr  output  2  timer register address (00 startstop, 01 timer1, 10 timer2).
REQ-014 SHALL have port wdata  output  8  timer write data.
REQ-015 SHALL have port rdata  input  8  timer read data.
REQ-016 SHALL have port busy  output  1  high while a sequence runs.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a sequence completes.
REQ-018 SHALL have port err  output  1  sticky readback-mismatch flag.

Function
REQ-019 SHALL use FSM states IDLE, W_SETUP, W_STROBE, R_SETUP, R_STROBE, FIN.
REQ-020 SHALL accept requests only in IDLE; stop_req wins if both requests are high in the same cycle; requests while busy are ignored.
REQ-021 SHALL capture cfg_t1/cfg_t2 on start accept; later input changes have no effect on the running sequence.
REQ-022 Start sequence SHALL be the write list: (00,CLR_CODE), (01,t1), (10,t2), (00,RUN_CODE); stop sequence SHALL be the single write (00,8'h00).
REQ-023 Each write SHALL take 2 cycles: W_SETUP drives addr/wdata with write=0; W_STROBE holds addr/wdata with write=1.
REQ-024 After the final write SHALL enter FIN for 1 cycle: done=1, addr=00, wdata=00, then IDLE; a start sequence without verify SHALL therefore raise done on cycle 9 after accept.
REQ-025 Outside W_STROBE/R_STROBE, write/read SHALL be 0; write and read SHALL never be high together.
REQ-026 busy SHALL be high from the cycle after accept through FIN inclusive.
REQ-027 sel SHALL equal SEL_VAL at all times after reset.

Reset
REQ-028 On rst_n=0, all outputs SHALL go to 0 immediately and the FSM SHALL go to IDLE, including mid-sequence; err SHALL clear.
REQ-029 After rst_n rises, SHALL issue no bus activity until a request arrives.

Configuration
REQ-030 With TIMER_SEQ_VERIFY_EN defined: after the last start write, SHALL read addr 01 then 10 (R_SETUP 1 cycle, R_STROBE 1 cycle read=1, rdata sampled at end of R_STROBE) and set err if either read differs from the captured value, then enter FIN (done on cycle 13).
REQ-031 Without TIMER_SEQ_VERIFY_EN: no read cycles; read SHALL be tied 0; err SHALL be tied 0.
REQ-032 The stop sequence SHALL never perform readback.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the address constants ADDR_SS/ADDR_T1/ADDR_T2, and the step-table entry type {addr, data}.
REQ-034 SHALL be a single module; no sub-module is required.

Verification
REQ-035 Reset, then start_req with t1=8'h49, t2=8'h09 -> writes (00,80), (01,49), (10,09), (00,01), each write pulse 1 cycle; done on cycle 9 without verify.
REQ-036 stop_req in IDLE -> single write (00,00); done 3 cycles after accept; busy high for those cycles.
REQ-037 start_req and stop_req in the same cycle -> only (00,00) is written.
REQ-038 start_req while busy -> ignored; exactly 4 writes occur; cfg_t1 changed mid-sequence -> original value written.
REQ-039 rst_n low during (01,49) W_STROBE -> write=0 and busy=0 at once; no further writes after release.
REQ-040 VERIFY_EN with timer model returning 8'h48 at addr 01 -> err=1 after done; a correct model -> err=0 and done on cycle 13.

Source files
------------

// File: rtl/timer_seq_pkg.sv
// Shared types and constants for the timer_seq bus sequencer.
package timer_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    R_SETUP  = 3'd3,
    R_STROBE = 3'd4,
    FIN      = 3'd5
  } state_e;

  localparam logic [1:0] ADDR_SS = 2'b00;
  localparam logic [1:0] ADDR_T1 = 2'b01;
  localparam logic [1:0] ADDR_T2 = 2'b10;

  // Index of the final write in the start list.
  localparam logic [1:0] START_LAST_IDX = 2'd3;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } step_t;

endpackage

// File: rtl/timer_seq.sv
// timer_seq: drives the configure/start and stop write sequences onto an external timer bus.
// Defining TIMER_SEQ_VERIFY_EN adds a readback of timer1/timer2 after a start sequence.
module timer_seq
  import timer_seq_pkg::*;
#(
  parameter logic       SEL_VAL  = 1'b0,
  parameter logic [7:0] CLR_CODE = 8'h80,
  parameter logic [7:0] RUN_CODE = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic [7:0] cfg_t1,
  input  logic [7:0] cfg_t2,
  output logic       sel,
  output logic       write,
  output logic       read,
  output logic [1:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       stop_q, stop_d;
  logic [7:0] t1_q, t1_d;
  logic [7:0] t2_q, t2_d;
  logic       rd_idx_q, rd_idx_d;
  logic       err_q, err_d;

  logic       sel_q;
  logic       write_q, write_d;
  logic       read_q, read_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  step_t      step_s;

`ifndef TIMER_SEQ_VERIFY_EN
  logic unused_rdata_s;
  assign unused_rdata_s = ^rdata;
`endif

  function automatic step_t step_at(input logic is_stop, input logic [1:0] idx,
                                    input logic [7:0] t1, input logic [7:0] t2);
    step_t s;
    if (is_stop) begin
      s = '{addr: ADDR_SS, data: 8'h00};
    end else begin
      case (idx)
        2'd0:    s = '{addr: ADDR_SS, data: CLR_CODE};
        2'd1:    s = '{addr: ADDR_T1, data: t1};
        2'd2:    s = '{addr: ADDR_T2, data: t2};
        default: s = '{addr: ADDR_SS, data: RUN_CODE};
      endcase
    end
    return s;
  endfunction

  // Next-state logic: request arbitration, write stepping and optional readback
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    t1_d     = t1_q;
    t2_d     = t2_q;
    rd_idx_d = rd_idx_q;
`ifdef TIMER_SEQ_VERIFY_EN
    err_d    = err_q;
`else
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (stop_req) begin
          state_d = W_SETUP;
          idx_d   = 2'd0;
          stop_d  = 1'b1;
        end else if (start_req) begin
          state_d = W_SETUP;
          idx_d   = 2'd0;
          stop_d  = 1'b0;
          t1_d    = cfg_t1;
          t2_d    = cfg_t2;
        end else begin
          state_d = IDLE;
        end
      end
      W_SETUP: state_d = W_STROBE;
      W_STROBE: begin
        if (stop_q || (idx_q == START_LAST_IDX)) begin
`ifdef TIMER_SEQ_VERIFY_EN
          if (stop_q) begin
            state_d = FIN;
          end else begin
            state_d  = R_SETUP;
            rd_idx_d = 1'b0;
          end
`else
          state_d = FIN;
`endif
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = W_SETUP;
        end
      end
      R_SETUP: state_d = R_STROBE;
      R_STROBE: begin
`ifdef TIMER_SEQ_VERIFY_EN
        if (rdata != (rd_idx_q ? t2_q : t1_q)) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
`endif
        if (rd_idx_q) begin
          state_d = FIN;
        end else begin
          rd_idx_d = 1'b1;
          state_d  = R_SETUP;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus output decode from the next state so the outputs can be registered
  always_comb begin
    step_s  = step_at(stop_d, idx_d, t1_d, t2_d);
    write_d = 1'b0;
    read_d  = 1'b0;
    addr_d  = ADDR_SS;
    wdata_d = 8'h00;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FIN);
    case (state_d)
      W_SETUP: begin
        addr_d  = step_s.addr;
        wdata_d = step_s.data;
      end
      W_STROBE: begin
        addr_d  = step_s.addr;
        wdata_d = step_s.data;
        write_d = 1'b1;
      end
      R_SETUP: addr_d = rd_idx_d ? ADDR_T2 : ADDR_T1;
      R_STROBE: begin
        addr_d = rd_idx_d ? ADDR_T2 : ADDR_T1;
`ifdef TIMER_SEQ_VERIFY_EN
        read_d = 1'b1;
`endif
      end
      default: begin
        addr_d  = ADDR_SS;
        wdata_d = 8'h00;
      end
    endcase
  end

  // Sequence state and captured configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      stop_q   <= 1'b0;
      t1_q     <= 8'h00;
      t2_q     <= 8'h00;
      rd_idx_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      rd_idx_q <= rd_idx_d;
      err_q    <= err_d;
    end
  end

  // Registered bus and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 1'b0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      addr_q  <= 2'b00;
      wdata_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sel_q   <= SEL_VAL;
      write_q <= write_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sel   = sel_q;
  assign write = write_q;
  assign read  = read_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
